// File: rtl/exe_mem_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// exe_mem_skid_reg_pkg
//   Shared definitions for the EXE->MEM skid register:
//     - skid_state_e : occupancy state of the two-entry buffer
//     - entry layout : one entry is {ctrl[2:0], dest, aluRes, valRm}, packed
//                      MSB to LSB; the helpers below give widths and offsets
//                      so the top and the entry register agree on the layout.
// -----------------------------------------------------------------------------
package exe_mem_skid_reg_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,   // no valid entry
        S_ONE   = 2'd1,   // head valid
        S_TWO   = 2'd2    // head and skid valid
    } skid_state_e;

    // Control field bit positions inside the 3-bit ctrl field
    localparam int CTRL_W      = 3;
    localparam int CTRL_WB_BIT = 2;
    localparam int CTRL_RD_BIT = 1;
    localparam int CTRL_WR_BIT = 0;

    function automatic int entry_w(input int dest_w, input int data_w);
        return CTRL_W + dest_w + 2 * data_w;
    endfunction

    // valRm occupies the low DATA_W bits, then aluRes, then dest, then ctrl
    function automatic int off_alures(input int data_w);
        return data_w;
    endfunction

    function automatic int off_dest(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int off_ctrl(input int dest_w, input int data_w);
        return 2 * data_w + dest_w;
    endfunction

endpackage

// File: rtl/exe_mem_skid_reg_entry.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
//   W-bit register with synchronous clear and load enable. Used for both the
//   head and the skid entry of exe_mem_skid_reg. When neither clr nor load is
//   asserted the contents are held, which is what keeps the head bit-stable
//   while MEM is not ready.
// Ports
//   clk   in  1  clock
//   clr   in  1  synchronous clear (dominates load)
//   load  in  1  capture d on the next posedge
//   d     in  W  next entry value
//   q     out W  stored entry
// -----------------------------------------------------------------------------
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // NOTE: the hold path (q_d = q_q) is the first assignment so every branch
    // leaves q_d defined and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/exe_mem_skid_reg.sv
// -----------------------------------------------------------------------------
// exe_mem_skid_reg
//   EXE->MEM pipeline register with a two-entry skid buffer. The head entry
//   drives the MEM request and stays bit-stable until MEM accepts it; one
//   further instruction is absorbed into the skid entry so the upstream freeze
//   can be registered (no combinational path from memReady to freezeOut).
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   exeValid/exeWbEn/exeMemRead/
//   exeMemWrite/exeDest/
//   exeAluRes/exeValRm           instruction presented by EXE
//   freezeOut                    registered; 1 = upstream must hold
//   memReady                     MEM completes the head this cycle
//   wbEn/memRead/memWrite        head controls, 0 while head empty
//   dest/aluRes/valRm            head data, held while head empty
//   stallCount                   saturating count of stalled head cycles
// -----------------------------------------------------------------------------
module exe_mem_skid_reg
    import exe_mem_skid_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exeValid,
    input  logic              exeWbEn,
    input  logic              exeMemRead,
    input  logic              exeMemWrite,
    input  logic [DEST_W-1:0] exeDest,
    input  logic [DATA_W-1:0] exeAluRes,
    input  logic [DATA_W-1:0] exeValRm,
    output logic              freezeOut,
    input  logic              memReady,
    output logic              wbEn,
    output logic              memRead,
    output logic              memWrite,
    output logic [DEST_W-1:0] dest,
    output logic [DATA_W-1:0] aluRes,
    output logic [DATA_W-1:0] valRm,
    output logic [CNT_W-1:0]  stallCount
);

    localparam int ENTRY_W  = entry_w(DEST_W, DATA_W);
    localparam int OFF_ALU  = off_alures(DATA_W);
    localparam int OFF_DEST = off_dest(DATA_W);
    localparam int OFF_CTRL = off_ctrl(DEST_W, DATA_W);

    skid_state_e        state_q, state_d;
    logic               freeze_q, freeze_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] skid_q;
    logic               head_load, skid_load, head_from_skid;
    logic               head_valid, push, consume;

    assign in_entry   = {exeWbEn, exeMemRead, exeMemWrite, exeDest, exeAluRes, exeValRm};
    assign head_valid = (state_q != S_EMPTY);
    assign push       = exeValid & ~freeze_q;
    assign consume    = head_valid & memReady;

    // Occupancy FSM: decides which entry registers load this cycle.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_load = 1'b1;
                    state_d   = S_ONE;
                end
            end
            S_ONE: begin
                if (push && consume) begin
                    head_load = 1'b1;          // back-to-back, no bubble
                end else if (consume) begin
                    state_d   = S_EMPTY;       // head data left in place
                end else if (push) begin
                    skid_load = 1'b1;
                    state_d   = S_TWO;
                end
            end
            S_TWO: begin
                // push is impossible here: freeze_q is high in this state
                if (consume) begin
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                    state_d        = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign head_d = head_from_skid ? skid_q : in_entry;

    // freeze is registered from the next state, so it tracks state_q == S_TWO
    // exactly while coming straight out of a flop.
    assign freeze_d = (state_d == S_TWO);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_valid && !memReady && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            freeze_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            freeze_q    <= freeze_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_entry_reg #(.W(ENTRY_W)) u_head (
        .clk  (clk),
        .clr  (rst),
        .load (head_load),
        .d    (head_d),
        .q    (head_q)
    );

    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk  (clk),
        .clr  (rst),
        .load (skid_load),
        .d    (in_entry),
        .q    (skid_q)
    );

    assign freezeOut  = freeze_q;
    assign wbEn       = head_valid & head_q[OFF_CTRL + CTRL_WB_BIT];
    assign memRead    = head_valid & head_q[OFF_CTRL + CTRL_RD_BIT];
    assign memWrite   = head_valid & head_q[OFF_CTRL + CTRL_WR_BIT];
    assign dest       = head_q[OFF_DEST +: DEST_W];
    assign aluRes     = head_q[OFF_ALU +: DATA_W];
    assign valRm      = head_q[0 +: DATA_W];
    assign stallCount = stall_cnt_q;

endmodule
